// File: rtl/lcd_bus_driver.sv
// Write-only character-LCD bus driver: one start edge produces one RS/DATA
// setup phase, an EN strobe and a hold phase, followed by a one-cycle oDone.
module lcd_bus_driver #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned EN_CYC    = 16,
   parameter int unsigned HOLD_CYC  = 2
)(
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic [7:0] iDATA,
   input  logic       iRS,
   input  logic       iStart,
   output logic       oDone,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_RS
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETUP  = 3'd1;
   localparam logic [2:0] ENABLE = 3'd2;
   localparam logic [2:0] HOLD   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   // Each phase ends when the counter reaches its parameter minus one.
   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 32'd1);
   localparam logic [7:0] EN_LAST    = 8'(EN_CYC - 32'd1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 32'd1);

   logic [2:0] state_r;
   logic [2:0] stateNext_s;
   logic [7:0] cnt_r;
   logic [7:0] cntNext_s;
   logic       prevStart_r;
   logic       startDet_s;
   logic       enNext_s;
   logic       doneNext_s;
   logic [7:0] dataNext_s;
   logic       rsNext_s;

   assign startDet_s = iStart & ~prevStart_r;
   assign LCD_RW     = 1'b0;

   // Next-state, counter and output-register values for the transfer sequencer.
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      enNext_s    = LCD_EN;
      doneNext_s  = 1'b0;
      dataNext_s  = LCD_DATA;
      rsNext_s    = LCD_RS;
      case (state_r)
         IDLE: begin
            if (startDet_s) begin
               dataNext_s  = iDATA;
               rsNext_s    = iRS;
               cntNext_s   = 8'd0;
               stateNext_s = SETUP;
            end else begin
               stateNext_s = IDLE;
            end
         end
         SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               enNext_s    = 1'b1;
               cntNext_s   = 8'd0;
               stateNext_s = ENABLE;
            end else begin
               cntNext_s   = cnt_r + 8'd1;
            end
         end
         ENABLE: begin
            if (cnt_r == EN_LAST) begin
               enNext_s    = 1'b0;
               cntNext_s   = 8'd0;
               stateNext_s = HOLD;
            end else begin
               cntNext_s   = cnt_r + 8'd1;
            end
         end
         HOLD: begin
            if (cnt_r == HOLD_LAST) begin
               doneNext_s  = 1'b1;
               cntNext_s   = 8'd0;
               stateNext_s = DONE;
            end else begin
               cntNext_s   = cnt_r + 8'd1;
            end
         end
         DONE: begin
            doneNext_s  = 1'b0;
            stateNext_s = IDLE;
         end
         default: begin
            enNext_s    = 1'b0;
            cntNext_s   = 8'd0;
            stateNext_s = IDLE;
         end
      endcase
   end

   // State, counter, start-edge history and all LCD-facing output flops.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_r     <= IDLE;
         cnt_r       <= 8'd0;
         prevStart_r <= 1'b0;
         oDone       <= 1'b0;
         LCD_EN      <= 1'b0;
         LCD_RS      <= 1'b0;
         LCD_DATA    <= 8'h00;
      end else begin
         state_r     <= stateNext_s;
         cnt_r       <= cntNext_s;
         prevStart_r <= iStart;
         oDone       <= doneNext_s;
         LCD_EN      <= enNext_s;
         LCD_RS      <= rsNext_s;
         LCD_DATA    <= dataNext_s;
      end
   end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench: two drivers (default and minimum timing) share stimulus;
// a transfer model predicts accepted starts and the monitor checks every cycle.
module tb_lcd_bus_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] iDATA = 8'h00;
   logic       iRS = 1'b0;
   logic       iStart = 1'b0;

   logic       doneW [2];
   logic [7:0] dataW [2];
   logic       rwW   [2];
   logic       enW   [2];
   logic       rsW   [2];

   typedef struct {
      int         dut;
      int         k;
      logic [7:0] data;
      logic       rs;
   } xfer_t;

   xfer_t      q[$];
   int         freeAt [2];
   logic [7:0] lastData [2];
   logic       lastRs [2];
   logic       prevModel = 1'b0;
   int         edgeCnt = 0;
   int         tests = 0;
   int         fails = 0;

   lcd_bus_driver dut0 (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
      .oDone(doneW[0]), .LCD_DATA(dataW[0]), .LCD_RW(rwW[0]), .LCD_EN(enW[0]), .LCD_RS(rsW[0])
   );

   lcd_bus_driver #(.SETUP_CYC(1), .EN_CYC(1), .HOLD_CYC(1)) dut1 (
      .iCLK(clk), .iRST_N(rst_n), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
      .oDone(doneW[1]), .LCD_DATA(dataW[1]), .LCD_RW(rwW[1]), .LCD_EN(enW[1]), .LCD_RS(rsW[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   function automatic int sOf(int d); return (d == 0) ? 2 : 1; endfunction
   function automatic int eOf(int d); return (d == 0) ? 16 : 1; endfunction
   function automatic int hOf(int d); return (d == 0) ? 2 : 1; endfunction

   function automatic int firstIdx(int d);
      for (int i = 0; i < q.size(); i++)
         if (q[i].dut == d) return i;
      return -1;
   endfunction

   task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, edgeCnt, act, exp);
      end
   endtask

   // One clock of stimulus; the model decides whether the next edge starts a transfer.
   task automatic drive_cycle(input logic st, input logic [7:0] dat, input logic rs, input logic rstn);
      int nxt;
      @(negedge clk);
      rst_n  = rstn;
      iStart = st;
      iDATA  = dat;
      iRS    = rs;
      nxt    = edgeCnt + 1;
      if (!rstn) begin
         prevModel = 1'b0;
      end else begin
         if (st && !prevModel) begin
            for (int d = 0; d < 2; d++) begin
               if (nxt >= freeAt[d]) begin
                  q.push_back('{dut: d, k: nxt, data: dat, rs: rs});
                  freeAt[d] = nxt + sOf(d) + eOf(d) + hOf(d) + 2;
               end
            end
         end
         prevModel = st;
      end
   endtask

   // Mid-cycle reset: everything drops at once and pending transfers are forgotten.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      q.delete();
      prevModel = 1'b0;
      for (int d = 0; d < 2; d++) begin
         freeAt[d] = 0;
         lastData[d] = 8'h00;
         lastRs[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("async_en", d, 32'(enW[d]), 32'd0);
         chk("async_done", d, 32'(doneW[d]), 32'd0);
         chk("async_data", d, 32'(dataW[d]), 32'd0);
         chk("async_rs", d, 32'(rsW[d]), 32'd0);
      end
   endtask

   int         mN;
   int         mFi;
   int         mK;
   logic       mAct;
   logic       expEn;
   logic       expDone;
   logic [7:0] expData;
   logic       expRs;

   // Monitor: compares every output against the oldest pending transfer of each DUT.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk("rw", d, 32'(rwW[d]), 32'd0);
         if (!rst_n) begin
            chk("rst_en", d, 32'(enW[d]), 32'd0);
            chk("rst_done", d, 32'(doneW[d]), 32'd0);
            chk("rst_data", d, 32'(dataW[d]), 32'd0);
            chk("rst_rs", d, 32'(rsW[d]), 32'd0);
         end else begin
            mN   = edgeCnt;
            mFi  = firstIdx(d);
            mAct = 1'b0;
            if (mFi >= 0) begin
               if (q[mFi].k <= mN) mAct = 1'b1;
            end
            if (mAct) begin
               mK      = q[mFi].k;
               expEn   = (mN >= mK + sOf(d)) && (mN < mK + sOf(d) + eOf(d));
               expDone = (mN == mK + sOf(d) + eOf(d) + hOf(d));
               expData = q[mFi].data;
               expRs   = q[mFi].rs;
            end else begin
               expEn   = 1'b0;
               expDone = 1'b0;
               expData = lastData[d];
               expRs   = lastRs[d];
            end
            chk("en", d, 32'(enW[d]), 32'(expEn));
            chk("done", d, 32'(doneW[d]), 32'(expDone));
            chk("data", d, 32'(dataW[d]), 32'(expData));
            chk("rs", d, 32'(rsW[d]), 32'(expRs));
            if (mAct && expDone) begin
               lastData[d] = expData;
               lastRs[d]   = expRs;
               q.delete(mFi);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int d = 0; d < 2; d++) begin
         freeAt[d] = 0;
         lastData[d] = 8'h00;
         lastRs[d] = 1'b0;
      end
      repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Command 38 with start held high, then a late toggle with FF during ENABLE.
      repeat (6) drive_cycle(1'b1, 8'h38, 1'b0, 1'b1);
      drive_cycle(1'b0, 8'hFF, 1'b1, 1'b1);
      repeat (30) drive_cycle(1'b1, 8'hFF, 1'b1, 1'b1);

      // Drop start, then data write 57.
      repeat (2) drive_cycle(1'b0, 8'h57, 1'b1, 1'b1);
      repeat (3) drive_cycle(1'b1, 8'h57, 1'b1, 1'b1);
      repeat (30) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Reset during ENABLE with start held high through release.
      repeat (2) drive_cycle(1'b0, 8'hA5, 1'b0, 1'b1);
      w = 0;
      drive_cycle(1'b1, 8'hA5, 1'b0, 1'b1);
      while (enW[0] !== 1'b1 && w < 40) begin
         drive_cycle(1'b1, 8'hA5, 1'b0, 1'b1);
         w++;
      end
      chk("en_wait", 0, 32'(enW[0]), 32'd1);
      async_reset();
      repeat (2) drive_cycle(1'b1, 8'h3C, 1'b1, 1'b0);
      repeat (30) drive_cycle(1'b1, 8'h3C, 1'b1, 1'b1);
      repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 2500; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         if ($urandom_range(0, 399) == 0) begin
            async_reset();
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
         end
      end

      repeat (40) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("queue_drained", 0, 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lcd_bus_driver.md
LCD_BUS_DRIVER -- requirements
Module: lcd_bus_driver

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: clocks RS/DATA are stable with LCD_EN low before the EN rise; legal range 1..255.
REQ-002 SHALL have parameter EN_CYC, default 16: clocks LCD_EN is held high; legal range 1..255.
REQ-003 SHALL have parameter HOLD_CYC, default 2: clocks LCD_EN is low with RS/DATA held after the EN fall; legal range 1..255.
REQ-004 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- iCLK  input  1  system clock; all state changes on its rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iDATA  input  8  byte to write to the character LCD.
- iRS  input  1  register select: 0 = command, 1 = data.
- iStart  input  1  transfer request; level held by the sequencer until oDone is seen.
- oDone  output  1  one-cycle pulse marking transfer completion.
- LCD_DATA  output  8  LCD data bus.
- LCD_RW  output  1  LCD read/write select; write-only block.
- LCD_EN  output  1  LCD enable strobe.
- LCD_RS  output  1  LCD register select.

Function
REQ-005 SHALL register iStart every cycle into a previous-start flop and detect a start as iStart=1 with previous-start=0.
REQ-006 SHALL implement states IDLE, SETUP, ENABLE, HOLD, DONE with an 8-bit cycle counter.
REQ-007 In IDLE on a detected start at edge k, SHALL latch iDATA onto LCD_DATA and iRS onto LCD_RS, clear the counter, and enter SETUP.
REQ-008 SHALL hold SETUP for SETUP_CYC cycles, then at edge k+SETUP_CYC drive LCD_EN=1 and enter ENABLE.
REQ-009 SHALL hold ENABLE for EN_CYC cycles, then at edge k+SETUP_CYC+EN_CYC drive LCD_EN=0 and enter HOLD.
REQ-010 SHALL hold HOLD for HOLD_CYC cycles, then at edge k+SETUP_CYC+EN_CYC+HOLD_CYC assert oDone and enter DONE.
REQ-011 From DONE SHALL deassert oDone and return to IDLE on the next edge, so oDone is high for exactly one cycle.
REQ-012 With default parameters, oDone SHALL be high during the cycle after edge k+20.
REQ-013 SHALL ignore iDATA, iRS and start edges while not in IDLE; a start edge arriving outside IDLE is not queued.
REQ-014 A start edge detected in the cycle DONE returns to IDLE (edge k+21 at defaults) SHALL be accepted normally.
REQ-015 iStart held high continuously SHALL produce exactly one transfer; a new transfer requires iStart to be sampled low at least once.
REQ-016 LCD_DATA and LCD_RS SHALL be constant from edge k through the end of HOLD, and SHALL retain the last transferred values while in IDLE.
REQ-017 LCD_RW SHALL be constant 0 at all times.
REQ-018 LCD_EN SHALL be high only in ENABLE and SHALL be glitch-free, driven directly from a flop.
REQ-019 Counter compares SHALL be against parameter-1 so that each phase lasts exactly its parameter value; no counter wrap-around occurs within the legal range.

Reset
REQ-020 While iRST_N=0, SHALL asynchronously force state=IDLE, counter=0, previous-start=0, oDone=0, LCD_EN=0, LCD_RS=0, LCD_DATA=8'h00, LCD_RW=0.
REQ-021 Reset asserted mid-transfer SHALL drop LCD_EN immediately, abort the transfer and suppress oDone; no completion is reported for the aborted transfer.
REQ-022 If iStart=1 on the first edge after reset release, SHALL treat that edge as a start, because previous-start resets to 0.

Verification
REQ-023 Scenario: defaults; iDATA=8'h38, iRS=0, iStart rises at edge 0 and is held high -> LCD_DATA=38, LCD_RS=0 from edge 0; LCD_EN high edges 2..17; oDone single pulse after edge 20; no second transfer.
REQ-024 Scenario: iStart dropped after oDone, then iDATA=8'h57, iRS=1, iStart raised again -> second transfer with LCD_RS=1, LCD_DATA=57; LCD_DATA stays 57 afterward in IDLE.
REQ-025 Scenario: iDATA changed to 8'hFF and iStart toggled 0->1 during ENABLE -> LCD_DATA stays 38; only one oDone pulse is produced.
REQ-026 Scenario: iRST_N pulled low during ENABLE -> LCD_EN=0 asynchronously; all outputs reach their reset values; no oDone pulse.
REQ-027 Scenario: iStart=1 through reset release -> transfer begins on the first post-reset edge.
REQ-028 Scenario: SETUP_CYC=1, EN_CYC=1, HOLD_CYC=1 -> LCD_EN high for exactly one cycle; oDone pulse after edge k+3.
